fpu_cmp_issue: RTL and testbench
================================

Name: fpu_cmp_issue

Overview:
- Issue/classification stage directly upstream of the FPU compare unit.
- Accepts an operand pair from the FPU dispatcher over a valid/ready handshake and classifies each operand as inf, NaN or zero.
- Drives the compare unit's instruction handshake and parameter vector, captures its result, and returns it downstream over a second valid/ready handshake.
- NaN pairs bypass the compare unit entirely.

Parameters:
- BIT_WIDTH, 32: operand width. Binary32 field layout: sign [31], exp [30:23], frac [22:0].
- TIMEOUT_CYCLES, 64: cycles WAIT may last before abort. Used only with the optional feature.
- TO_W, 7: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept a pair
- in_a  in  BIT_WIDTH  operand A (becomes reg1)
- in_b  in  BIT_WIDTH  operand B (becomes reg2)
- cmp_instr_received  out  1  request to compare unit
- cmp_reg_params  out  6  {inf_b, inf_a, nan_b, nan_a, zero_b, zero_a}
- cmp_reg1  out  BIT_WIDTH  latched A
- cmp_reg2  out  BIT_WIDTH  latched B
- cmp_instr_finished  in  1  compare done
- cmp_reg_lo  in  BIT_WIDTH  compare result
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_data  out  BIT_WIDTH  result
- res_nan  out  1  result produced by NaN bypass
- res_err  out  1  result produced by timeout abort

Behaviour:
- Reset (rst=1 at a clk edge), synchronous, any state: state=IDLE, in_ready=1, cmp_instr_received=0, res_valid=0, res_nan=0, res_err=0, res_data=0, cmp_reg1=0, cmp_reg2=0, cmp_reg_params=0, timeout counter=0. Reset mid-WAIT drops cmp_instr_received the following cycle and discards the in-flight op.
- Classification, per operand (combinational on the latched operands):
  - NaN: exp==8'hFF and frac!=0.
  - inf: exp==8'hFF and frac==0.
  - zero: exp==0 and frac==0.
  - Denormals classify as none of these.
- Packing: bit 0 of each pair = A, bit 1 = B.
- FSM states: IDLE, ISSUE, WAIT, RELEASE, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_a/in_b into cmp_reg1/cmp_reg2 and register cmp_reg_params from in_a/in_b in the same edge.
  - If nan_a or nan_b: go to OUT with res_data=in_a, res_nan=1. The compare unit is never started.
  - Otherwise go to ISSUE.
- ISSUE: assert cmp_instr_received=1; go to WAIT.
- WAIT:
  - Hold cmp_instr_received=1 and hold operands/params stable.
  - On cmp_instr_finished=1: capture cmp_reg_lo into res_data, deassert cmp_instr_received, go to RELEASE.
- RELEASE:
  - cmp_instr_received=0 for exactly one cycle so the compare unit clears its finished flag.
  - Go to OUT with res_valid=1.
- OUT:
  - res_valid=1; res_data, res_nan and res_err stable until res_ready=1.
  - On res_ready: res_valid=0, res_nan=0, res_err=0; go to IDLE.
- in_ready is 1 only in IDLE. Back-to-back throughput is one op per 5 cycles on the compare path and one op per 2 cycles on the bypass.
- Latency from in_valid accepted to res_valid: bypass 1 cycle; compare path 3 cycles + compare-unit latency (1 cycle gives res_valid 4 cycles after accept).
- cmp_instr_finished outside WAIT is ignored.
- res_ready held high with no result pending has no effect.

Optional Feature:
- Macro FPU_CMP_TIMEOUT_EN.
- Defined:
  - TO_W-bit counter cleared on entry to WAIT, incremented each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without cmp_instr_finished: drop cmp_instr_received, set res_data=cmp_reg1, res_err=1, go to RELEASE.
  - cmp_instr_finished on the same cycle as expiry wins: normal capture, res_err=0.
- Undefined: no counter; WAIT lasts indefinitely; res_err tied to 0.

Test Plan:
- A=0x3F800000 (1.0), B=0x40000000 (2.0); model returns 0x40000000 after 1 cycle:
  - cmp_reg_params=6'b000000; cmp_instr_received high for exactly 2 cycles (ISSUE, WAIT).
  - res_valid 4 cycles after accept; res_data=0x40000000; res_nan=0.
- A=0x7FC00000 (qNaN), B=0x3F800000:
  - cmp_instr_received never rises.
  - res_valid 1 cycle after accept; res_data=0x7FC00000; res_nan=1.
- A=0x7F800000 (+inf), B=0x00000000 (+0): cmp_reg_params=6'b010010; compare path taken.
- A=0x80000000 (-0), B=0xFF800000 (-inf): cmp_reg_params=6'b100001; compare path taken.
- Result backpressure: res_ready=0 for 5 cycles after res_valid:
  - res_data stable; in_ready=0 throughout; a new in_valid is not accepted until the cycle after res_ready=1.
- Reset and timeout:
  - rst=1 during WAIT: next cycle cmp_instr_received=0, in_ready=1, res_valid=0.
  - With FPU_CMP_TIMEOUT_EN and the model never finishing: res_err=1 and res_data=A exactly TIMEOUT_CYCLES+2 cycles after WAIT entry.

Source files
------------

// File: rtl/fpu_cmp_issue_if.sv
// Handshake bundle for fpu_cmp_issue: dispatcher input, compare-unit request/response and
// result output. The slave view belongs to the issue stage, the master view to its environment.
interface fpu_cmp_issue_if #(
  parameter int unsigned BIT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] in_a;
  logic [BIT_WIDTH-1:0] in_b;

  logic                 cmp_instr_received;
  logic [5:0]           cmp_reg_params;
  logic [BIT_WIDTH-1:0] cmp_reg1;
  logic [BIT_WIDTH-1:0] cmp_reg2;
  logic                 cmp_instr_finished;
  logic [BIT_WIDTH-1:0] cmp_reg_lo;

  logic                 res_valid;
  logic                 res_ready;
  logic [BIT_WIDTH-1:0] res_data;
  logic                 res_nan;
  logic                 res_err;

  modport slave (
    input  in_valid, in_a, in_b, cmp_instr_finished, cmp_reg_lo, res_ready,
    output in_ready, cmp_instr_received, cmp_reg_params, cmp_reg1, cmp_reg2,
           res_valid, res_data, res_nan, res_err
  );

  modport master (
    output in_valid, in_a, in_b, cmp_instr_finished, cmp_reg_lo, res_ready,
    input  in_ready, cmp_instr_received, cmp_reg_params, cmp_reg1, cmp_reg2,
           res_valid, res_data, res_nan, res_err
  );
endinterface

// File: rtl/fpu_cmp_issue.sv
// Issue/classification stage ahead of the FPU compare unit; NaN pairs bypass the unit.
// Defining FPU_CMP_TIMEOUT_EN adds an abort when the compare unit never finishes.
module fpu_cmp_issue #(
  parameter int unsigned BIT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TO_W           = 7
) (
  input logic            clk,
  input logic            rst,
  fpu_cmp_issue_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StRelease, StOut} state_e;

  if ((64'd1 << TO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_to_w_too_narrow
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end

  // Returns {inf, nan, zero} for the magnitude bits of a binary32 operand.
  function automatic logic [2:0] classify(input logic [30:0] mag);
    logic exp_ones, exp_zero, frac_zero;
    exp_ones  = &mag[30:23];
    exp_zero  = ~|mag[30:23];
    frac_zero = ~|mag[22:0];
    return {exp_ones & frac_zero, exp_ones & ~frac_zero, exp_zero & frac_zero};
  endfunction

  logic [2:0] cls_a, cls_b;
  logic [5:0] params_in;

  assign cls_a     = classify(bus.in_a[30:0]);
  assign cls_b     = classify(bus.in_b[30:0]);
  assign params_in = {cls_b[2], cls_a[2], cls_b[1], cls_a[1], cls_b[0], cls_a[0]};

  state_e               state_q;
  logic                 in_ready_q;
  logic                 req_q;
  logic [5:0]           params_q;
  logic [BIT_WIDTH-1:0] reg1_q;
  logic [BIT_WIDTH-1:0] reg2_q;
  logic                 res_valid_q;
  logic                 res_nan_q;
  logic [BIT_WIDTH-1:0] res_data_q;
`ifdef FPU_CMP_TIMEOUT_EN
  logic                 res_err_q;
  logic [TO_W-1:0]      to_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      req_q       <= 1'b0;
      params_q    <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      res_valid_q <= 1'b0;
      res_nan_q   <= 1'b0;
      res_data_q  <= '0;
`ifdef FPU_CMP_TIMEOUT_EN
      res_err_q   <= 1'b0;
      to_cnt_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            reg1_q     <= bus.in_a;
            reg2_q     <= bus.in_b;
            params_q   <= params_in;
            in_ready_q <= 1'b0;
            if (cls_a[1] || cls_b[1]) begin
              // NaN pair: result is operand A, compare unit stays untouched.
              res_data_q  <= bus.in_a;
              res_nan_q   <= 1'b1;
              res_valid_q <= 1'b1;
              state_q     <= StOut;
            end else begin
              req_q   <= 1'b1;
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          state_q <= StWait;
`ifdef FPU_CMP_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        StWait: begin
          if (bus.cmp_instr_finished) begin
            res_data_q <= bus.cmp_reg_lo;
            req_q      <= 1'b0;
            state_q    <= StRelease;
          end
`ifdef FPU_CMP_TIMEOUT_EN
          else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
            res_data_q <= reg1_q;
            res_err_q  <= 1'b1;
            req_q      <= 1'b0;
            state_q    <= StRelease;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
`endif
        end
        StRelease: begin
          // One idle request cycle lets the compare unit drop its finished flag.
          res_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            res_nan_q   <= 1'b0;
`ifdef FPU_CMP_TIMEOUT_EN
            res_err_q   <= 1'b0;
`endif
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready           = in_ready_q;
  assign bus.cmp_instr_received = req_q;
  assign bus.cmp_reg_params     = params_q;
  assign bus.cmp_reg1           = reg1_q;
  assign bus.cmp_reg2           = reg2_q;
  assign bus.res_valid          = res_valid_q;
  assign bus.res_nan            = res_nan_q;
  assign bus.res_data           = res_data_q;
`ifdef FPU_CMP_TIMEOUT_EN
  assign bus.res_err            = res_err_q;
`else
  assign bus.res_err            = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_cmp_issue.sv
// Bench for fpu_cmp_issue: directed vector table, corner sequences and random ops checked
// against a transaction-level reference with a behavioural compare-unit model.
module tb_fpu_cmp_issue;
  localparam int unsigned W             = 32;
  localparam int unsigned TimeoutCycles = 64;
`ifdef FPU_CMP_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_cmp_issue_if #(.BIT_WIDTH(W)) bus ();

  fpu_cmp_issue #(
    .BIT_WIDTH     (W),
    .TIMEOUT_CYCLES(TimeoutCycles),
    .TO_W          (7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Compare-unit model: raises finished after model_lat request cycles (0 = never).
  int          model_lat = 1;
  logic [31:0] model_lo  = '0;
  int          fin_cnt   = 0;
  logic        fin       = 1'b0;

  always @(posedge clk) begin
    if (rst || !bus.cmp_instr_received) begin
      fin_cnt <= 0;
      fin     <= 1'b0;
    end else begin
      fin_cnt <= fin_cnt + 1;
      if (model_lat != 0 && fin_cnt + 1 >= model_lat) fin <= 1'b1;
    end
  end

  assign bus.cmp_instr_finished = fin;
  assign bus.cmp_reg_lo         = model_lo;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] lo;
    logic [5:0]  params;
    int          hold;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic int unsigned exp_of(input logic [31:0] x);
    return (int'(x) >>> 23) & 255;
  endfunction

  function automatic int unsigned frac_of(input logic [31:0] x);
    return x % (32'd1 << 23);
  endfunction

  function automatic bit is_nan(input logic [31:0] x);
    return exp_of(x) == 255 && frac_of(x) != 0;
  endfunction

  function automatic bit is_inf(input logic [31:0] x);
    return exp_of(x) == 255 && frac_of(x) == 0;
  endfunction

  function automatic bit is_zero(input logic [31:0] x);
    return exp_of(x) == 0 && frac_of(x) == 0;
  endfunction

  function automatic logic [5:0] ref_params(input logic [31:0] a, input logic [31:0] b);
    int v;
    v = 32 * is_inf(b) + 16 * is_inf(a) + 8 * is_nan(b) + 4 * is_nan(a)
      + 2 * is_zero(b) + is_zero(a);
    return 6'(v);
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] s;
    s = 32'($urandom_range(0, 1)) << 31;
    case ($urandom_range(0, 5))
      0:       return s;
      1:       return s | 32'h7F80_0000;
      2:       return s | 32'h7F80_0000 | 32'($urandom_range(1, 32'h7F_FFFF));
      3:       return s | 32'($urandom_range(1, 32'h7F_FFFF));
      default: return s | (32'($urandom_range(1, 254)) << 23) | 32'($urandom_range(0, 32'h7F_FFFF));
    endcase
  endfunction

  // Issue one pair from a negedge in IDLE; ends at a negedge back in IDLE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int lat,
                        input logic [31:0] lo, input logic [5:0] exp_params, input int hold);
    bit          nan, err, got;
    int          wait_c, exp_k, k, recv_c;
    logic [31:0] ed;
    nan = is_nan(a) || is_nan(b);
    if (nan) begin
      err = 1'b0; wait_c = 0; exp_k = 1; ed = a;
    end else begin
      err    = ToEn && (lat == 0 || lat > int'(TimeoutCycles) + 1);
      wait_c = err ? int'(TimeoutCycles) + 1 : lat;
      exp_k  = 3 + wait_c;
      ed     = err ? a : lo;
    end
    model_lat = lat;
    model_lo  = lo;
    check("in_ready before issue", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    k = 0; got = 1'b0; recv_c = 0;
    while (!got && k < 400) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check("cmp_reg_params", 32'(bus.cmp_reg_params), 32'(exp_params));
        check("cmp_reg1", bus.cmp_reg1, a);
        check("cmp_reg2", bus.cmp_reg2, b);
      end
      if (bus.cmp_instr_received) recv_c++;
      got = bus.res_valid;
    end
    check("res_valid seen", 32'(got), 1);
    check("res_valid latency", 32'(k), 32'(exp_k));
    check("request cycles", 32'(recv_c), 32'(nan ? 0 : 1 + wait_c));
    check("res_data", bus.res_data, ed);
    check("res_nan", 32'(bus.res_nan), 32'(nan));
    check("res_err", 32'(bus.res_err), 32'(err));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = ~a;
      bus.in_b     = b;
      @(negedge clk);
      check("held res_valid", 32'(bus.res_valid), 1);
      check("held res_data", bus.res_data, ed);
      check("in_ready under backpressure", 32'(bus.in_ready), 0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    @(negedge clk);
    check("res_valid after accept", 32'(bus.res_valid), 0);
    check("in_ready after accept", 32'(bus.in_ready), 1);
    check("res_nan cleared", 32'(bus.res_nan), 0);
    check("res_err cleared", 32'(bus.res_err), 0);
    if (hold > 0) check("pending pair not taken early", bus.cmp_reg1, a);
    bus.in_valid = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 1, 32'h4000_0000, 6'b000000, 0};
    vecs[1] = '{32'h7FC0_0000, 32'h3F80_0000, 1, 32'h1234_5678, 6'b000100, 0};
    vecs[2] = '{32'h7F80_0000, 32'h0000_0000, 1, 32'h0000_0001, 6'b010010, 0};
    vecs[3] = '{32'h8000_0000, 32'hFF80_0000, 2, 32'hFFFF_FFFF, 6'b100001, 0};
    vecs[4] = '{32'h3F80_0000, 32'h4000_0000, 1, 32'h4000_0000, 6'b000000, 5};
    vecs[5] = '{32'h0000_0001, 32'h7F80_0001, 3, 32'hAAAA_5555, 6'b001000, 0};
    vecs[6] = '{32'h0040_0000, 32'h8000_0000, 4, 32'h0BAD_F00D, 6'b000010, 1};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", 32'(bus.in_ready), 1);
    check("reset cmp_instr_received", 32'(bus.cmp_instr_received), 0);
    check("reset res_valid", 32'(bus.res_valid), 0);
    check("reset res_nan", 32'(bus.res_nan), 0);
    check("reset res_err", 32'(bus.res_err), 0);
    check("reset res_data", bus.res_data, 0);
    check("reset cmp_reg1", bus.cmp_reg1, 0);
    check("reset cmp_reg2", bus.cmp_reg2, 0);
    check("reset cmp_reg_params", 32'(bus.cmp_reg_params), 0);

    // Idle res_ready must not conjure a result.
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle res_ready res_valid", 32'(bus.res_valid), 0);
    check("idle res_ready in_ready", 32'(bus.in_ready), 1);
    bus.res_ready = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].lo, vecs[i].params, vecs[i].hold);

    // Reset while the compare unit never answers.
    model_lat    = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h3FC0_0000;
    bus.in_b     = 32'h4040_0000;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (ToEn ? 10 : 100) @(negedge clk);
    check("wait holds request", 32'(bus.cmp_instr_received), 1);
    check("no result while waiting", 32'(bus.res_valid), 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid-wait reset request", 32'(bus.cmp_instr_received), 0);
    check("mid-wait reset in_ready", 32'(bus.in_ready), 1);
    check("mid-wait reset res_valid", 32'(bus.res_valid), 0);
    check("mid-wait reset cmp_reg1", bus.cmp_reg1, 0);

`ifdef FPU_CMP_TIMEOUT_EN
    run_op(32'h3FC0_0000, 32'h4040_0000, 0, 32'hDEAD_BEEF, 6'b000000, 0);
    run_op(32'hC120_0000, 32'h0000_0000, TimeoutCycles + 1, 32'h5555_AAAA, 6'b000010, 0);
    run_op(32'h4120_0000, 32'h3F80_0000, TimeoutCycles + 2, 32'h5555_AAAA, 6'b000000, 2);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra, rb;
      ra = rand_op();
      rb = rand_op();
      run_op(ra, rb, $urandom_range(1, 4), $urandom, ref_params(ra, rb), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
